// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive control path.
package uart_rx_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned BIT_CNT_W = 4;

    // Supported oversampling ratios.
    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    // Frame phase encoding.
    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversampling edge counter and in-frame bit index counter.
module edge_bit_counter #(
    parameter int unsigned PWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic [PWIDTH-1:0] prescale_q,
    output logic [PWIDTH-1:0] edge_counter,
    output logic [3:0]        bit_count,
    output logic              bit_end
);

    // Last oversampling edge of the current bit.
    assign bit_end = enable && (edge_counter == (prescale_q - PWIDTH'(1)));

    // Edge counter wraps at bit end and advances the bit index.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            edge_counter <= '0;
            bit_count    <= '0;
        end else if (enable) begin
            if (bit_end) begin
                edge_counter <= '0;
                bit_count    <= bit_count + 4'd1;
            end else begin
                edge_counter <= edge_counter + PWIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: frame phases, checker enables and result pulses.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned PWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              par_en,
    input  logic [PWIDTH-1:0] prescale,
    input  logic              strt_glitch,
    input  logic              par_err,
    input  logic              stp_err,
    output logic [PWIDTH-1:0] edge_counter,
    output logic [3:0]        bit_count,
    output logic              dat_samp_en,
    output logic              deser_en,
    output logic              strt_chk_en,
    output logic              par_chk_en,
    output logic              stp_chk_en,
    output logic              data_valid,
    output logic              par_err_o,
    output logic              frm_err_o
);

    state_t            state, state_next;
    logic [PWIDTH-1:0] prescale_q, prescale_next;
    logic              par_en_q, par_en_next;
    logic              perr_q, perr_next;
    logic              dv_next, pe_next, fe_next;
    logic              cnt_enable, cnt_clear, bit_end;
    logic              active;
    logic [PWIDTH-1:0] half;

    edge_bit_counter #(
        .PWIDTH(PWIDTH)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .enable      (cnt_enable),
        .clear       (cnt_clear),
        .prescale_q  (prescale_q),
        .edge_counter(edge_counter),
        .bit_count   (bit_count),
        .bit_end     (bit_end)
    );

    // State, frame configuration and result pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            perr_q     <= 1'b0;
            data_valid <= 1'b0;
            par_err_o  <= 1'b0;
            frm_err_o  <= 1'b0;
        end else begin
            state      <= state_next;
            prescale_q <= prescale_next;
            par_en_q   <= par_en_next;
            perr_q     <= perr_next;
            data_valid <= dv_next;
            par_err_o  <= pe_next;
            frm_err_o  <= fe_next;
        end
    end

    // Next-state, configuration latching and end-of-frame verdict.
    always_comb begin
        state_next    = state;
        prescale_next = prescale_q;
        par_en_next   = par_en_q;
        perr_next     = perr_q;
        dv_next       = 1'b0;
        pe_next       = 1'b0;
        fe_next       = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_in) begin
                    prescale_next = prescale;
                    par_en_next   = par_en;
                    perr_next     = 1'b0;
                    state_next    = START;
                end
            end
            START: begin
                if (bit_end) state_next = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                if (bit_end && (bit_count == 4'(DWIDTH)))
                    state_next = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) begin
                    perr_next  = perr_q | par_err;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (perr_q)       pe_next = 1'b1;
                    else if (stp_err) fe_next = 1'b1;
                    else              dv_next = 1'b1;
                    if (!rx_in) begin
                        prescale_next = prescale;
                        par_en_next   = par_en;
                        perr_next     = 1'b0;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters run in any frame phase; they restart on every START entry and rest at 0 in IDLE.
    assign cnt_enable = (state != IDLE);
    assign cnt_clear  = (state_next == IDLE) || ((state_next == START) && (state != START));

    // Checker and sampler enables decoded from the current phase and edge position.
    assign active      = (state != IDLE);
    assign half        = prescale_q >> 1;
    assign dat_samp_en = active && (edge_counter >= (half - PWIDTH'(1)))
                                && (edge_counter <= (half + PWIDTH'(1)));
    assign strt_chk_en = (state == START);
    assign deser_en    = (state == DATA);
    assign par_chk_en  = (state == PARITY);
    assign stp_chk_en  = (state == STOP);

endmodule
